// File: rtl/bpred_pkg.sv
// Shared encodings, lookup metadata record and counter reset value for the gshare predictor.
package bpred_pkg;

    // Widest index/history the metadata record must carry (ENTRIES <= 1024).
    localparam int IDX_MAX = 10;

    typedef enum logic [1:0] {
        CORR_NONE = 2'b00,
        CORR_CNI  = 2'b10,
        CORR_PBT  = 2'b11
    } corr_e;

    typedef struct packed {
        logic               valid;
        logic               hit;
        logic               pred;
        logic [IDX_MAX-1:0] pht_idx;
        logic [IDX_MAX-1:0] ghr;
    } meta_t;

    function automatic logic [3:0] ctr_init(input int w);
        return 4'((1 << (w - 1)) - 1);
    endfunction

endpackage

// File: rtl/pht_array.sv
// Pattern history table: saturating counters with combinational read and
// registered update, so a same-cycle read of the written index sees the old count.
module pht_array
    import bpred_pkg::*;
#(
    parameter int ENTRIES = 64,
    parameter int CTR_W   = 2
) (
    input  logic                         CLK,
    input  logic                         nrst,
    input  logic [$clog2(ENTRIES)-1:0]   rd_idx,
    output logic [CTR_W-1:0]             rd_ctr,
    input  logic                         wr_en,
    input  logic [$clog2(ENTRIES)-1:0]   wr_idx,
    input  logic                         wr_taken
);

    localparam logic [CTR_W-1:0] CTR_INIT = CTR_W'(ctr_init(CTR_W));
    localparam logic [CTR_W-1:0] CTR_MAX  = '1;

    logic [CTR_W-1:0] ctr_q [ENTRIES];
    logic [CTR_W-1:0] ctr_d [ENTRIES];

    function automatic logic [CTR_W-1:0] sat_step(input logic [CTR_W-1:0] c, input logic up);
        if (up) begin
            return (c == CTR_MAX) ? c : c + 1'b1;
        end
        return (c == '0) ? c : c - 1'b1;
    endfunction

    assign rd_ctr = ctr_q[rd_idx];

    always_comb begin
        ctr_d = ctr_q;
        if (wr_en) begin
            ctr_d[wr_idx] = sat_step(ctr_q[wr_idx], wr_taken);
        end
    end

    always_ff @(posedge CLK) begin
        if (!nrst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                ctr_q[i] <= CTR_INIT;
            end
        end else begin
            ctr_q <= ctr_d;
        end
    end

endmodule

// File: rtl/bpred_gshare.sv
// Gshare branch predictor: direct-mapped BTB plus PC^GHR indexed PHT, with lookup
// metadata carried IF->ID->EXE for allocation, training and GHR recovery.
module bpred_gshare
    import bpred_pkg::*;
#(
    parameter int PC_W    = 10,
    parameter int ENTRIES = 64,
    parameter int HIST_W  = 6,
    parameter int CTR_W   = 2
) (
    input  logic            CLK,
    input  logic            nrst,
    input  logic [PC_W-1:0] if_PC,
    input  logic [PC_W-1:0] id_PC,
    input  logic [PC_W-1:0] id_branchtarget,
    input  logic            id_is_jump,
    input  logic            id_is_btype,
    input  logic [PC_W-1:0] exe_PC,
    input  logic            exe_is_btype,
    input  logic            exe_taken,
    input  logic [PC_W-1:0] exe_target,
    output logic            if_prediction,
    output logic [PC_W-1:0] if_PBT,
    output logic            id_jump_in_bht,
    output logic [1:0]      exe_correction,
    output logic            flush,
    output logic [PC_W-1:0] exe_PBT,
    output logic [PC_W-1:0] exe_CNI
);

    localparam int IW    = $clog2(ENTRIES);
    localparam int TAG_W = PC_W - IW;

    logic              btb_valid_q [ENTRIES];
    logic              btb_valid_d [ENTRIES];
    logic [TAG_W-1:0]  btb_tag_q   [ENTRIES];
    logic [TAG_W-1:0]  btb_tag_d   [ENTRIES];
    logic [PC_W-1:0]   btb_tgt_q   [ENTRIES];
    logic [PC_W-1:0]   btb_tgt_d   [ENTRIES];
    logic              btb_jmp_q   [ENTRIES];
    logic              btb_jmp_d   [ENTRIES];

    logic [HIST_W-1:0] ghr_q, ghr_d;
    meta_t             id_meta_q, id_meta_d, exe_meta_q, exe_meta_d, if_meta;

    logic [IW-1:0]     if_idx, id_idx, if_pht_idx, ghr_ext;
    logic [TAG_W-1:0]  if_tag, id_tag;
    logic [CTR_W-1:0]  if_ctr;
    logic              if_hit, if_cond, if_pred, alloc, exe_upd;
    corr_e             exe_corr;
    logic              unused_meta;

    // IF lookup
    assign if_idx     = if_PC[IW-1:0];
    assign if_tag     = if_PC[PC_W-1:IW];
    assign if_hit     = btb_valid_q[if_idx] && (btb_tag_q[if_idx] == if_tag);
    assign if_cond    = if_hit && !btb_jmp_q[if_idx];
    assign if_pht_idx = if_idx ^ ghr_ext;
    assign if_pred    = if_hit && (btb_jmp_q[if_idx] || if_ctr[CTR_W-1]);

    assign if_prediction = if_pred;
    assign if_PBT        = if_hit ? btb_tgt_q[if_idx] : '0;

    always_comb begin
        ghr_ext = '0;
        ghr_ext[HIST_W-1:0] = ghr_q;
    end

    always_comb begin
        if_meta = '0;
        if_meta.valid = 1'b1;
        if_meta.hit   = if_hit;
        if_meta.pred  = if_pred;
        if_meta.pht_idx[IW-1:0] = if_pht_idx;
        if_meta.ghr[HIST_W-1:0] = ghr_q;
    end

    pht_array #(
        .ENTRIES (ENTRIES),
        .CTR_W   (CTR_W)
    ) u_pht (
        .CLK      (CLK),
        .nrst     (nrst),
        .rd_idx   (if_pht_idx),
        .rd_ctr   (if_ctr),
        .wr_en    (exe_upd),
        .wr_idx   (exe_meta_q.pht_idx[IW-1:0]),
        .wr_taken (exe_taken)
    );

    // ID stage: allocate on miss, report jumps already redirected at fetch
    assign id_idx         = id_PC[IW-1:0];
    assign id_tag         = id_PC[PC_W-1:IW];
    assign id_jump_in_bht = id_is_jump && id_meta_q.hit && id_meta_q.pred;
    assign alloc          = (id_is_jump || id_is_btype) && !id_meta_q.hit && !flush;

    // EXE stage: resolve against the prediction made at fetch
    assign exe_upd = exe_is_btype && exe_meta_q.valid;

    always_comb begin
        exe_corr = CORR_NONE;
        if (exe_upd && (exe_meta_q.pred != exe_taken)) begin
            exe_corr = exe_meta_q.pred ? CORR_CNI : CORR_PBT;
        end
    end

    assign exe_correction = exe_corr;
    assign flush          = (exe_corr != CORR_NONE);
    assign exe_CNI        = exe_PC + PC_W'(1);
    assign exe_PBT        = (exe_corr == CORR_PBT) ? exe_target : '0;

    // Only the low index/history bits of the EXE record are consumed.
    assign unused_meta = ^exe_meta_q;

    always_comb begin
        ghr_d      = ghr_q;
        id_meta_d  = if_meta;
        exe_meta_d = id_meta_q;
        if (flush) begin
            ghr_d      = (exe_meta_q.ghr[HIST_W-1:0] << 1) | HIST_W'(exe_taken);
            id_meta_d  = '0;
            exe_meta_d = '0;
        end else if (if_cond) begin
            ghr_d = (ghr_q << 1) | HIST_W'(if_pred);
        end
    end

    always_comb begin
        btb_valid_d = btb_valid_q;
        btb_tag_d   = btb_tag_q;
        btb_tgt_d   = btb_tgt_q;
        btb_jmp_d   = btb_jmp_q;
        if (alloc) begin
            btb_valid_d[id_idx] = 1'b1;
            btb_tag_d[id_idx]   = id_tag;
            btb_tgt_d[id_idx]   = id_branchtarget;
            btb_jmp_d[id_idx]   = id_is_jump;
        end
    end

    always_ff @(posedge CLK) begin
        if (!nrst) begin
            ghr_q      <= '0;
            id_meta_q  <= '0;
            exe_meta_q <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                btb_valid_q[i] <= 1'b0;
            end
        end else begin
            ghr_q       <= ghr_d;
            id_meta_q   <= id_meta_d;
            exe_meta_q  <= exe_meta_d;
            btb_valid_q <= btb_valid_d;
        end
    end

    // Entry payload is qualified by the valid bit, so it needs no reset.
    always_ff @(posedge CLK) begin
        btb_tag_q <= btb_tag_d;
        btb_tgt_q <= btb_tgt_d;
        btb_jmp_q <= btb_jmp_d;
    end

endmodule

// File: doc/bpred_gshare.md
BPRED_GSHARE -- requirements
Module: bpred_gshare

Interface
REQ-001 Parameter PC_W, 10, word-address width of all PC and target ports (byte PC bits [PC_W+1:2]).
REQ-002 Parameter ENTRIES, 64, BTB and PHT depth; power of two, 4..1024.
REQ-003 Parameter HIST_W, 6, global history length; 0 < HIST_W <= log2(ENTRIES).
REQ-004 Parameter CTR_W, 2, PHT saturating-counter width; 1..4.
REQ-005 CLK  in  1  the only clock; all state updates on its rising edge.
REQ-006 nrst  in  1  reset, synchronous, active-low.
REQ-007 if_PC  in  PC_W  fetch word address for lookup.
REQ-008 id_PC, id_branchtarget  in  PC_W each  ID-stage PC and computed target.
REQ-009 id_is_jump, id_is_btype  in  1 each  ID instruction is JAL/JALR, or conditional branch.
REQ-010 exe_PC  in  PC_W; exe_is_btype  in  1; exe_taken  in  1: resolved conditional branch in EXE and its outcome.
REQ-011 exe_target  in  PC_W  resolved taken target of the EXE branch.
REQ-012 if_prediction  out  1; if_PBT  out  PC_W: predict taken, and the predicted target.
REQ-013 id_jump_in_bht  out  1  ID jump was already redirected at IF; core suppresses the ID redirect.
REQ-014 exe_correction  out  2; flush  out  1; exe_PBT, exe_CNI  out  PC_W each: redirect control and addresses.

Function
REQ-015 BTB: ENTRIES x {valid, tag = PC[PC_W-1:log2E], target, is_jump}, indexed by PC[log2E-1:0].
REQ-016 PHT: ENTRIES x CTR_W counters, index = PC[log2E-1:0] XOR zero-extended GHR.
REQ-017 Lookup is combinational in the same cycle; if_prediction = BTB hit AND (is_jump OR counter MSB); if_PBT = BTB target, 0 on miss.
REQ-018 Lookup metadata {hit, pred, pht_idx, ghr_snapshot} shall pipeline internally IF->ID->EXE, one stage per cycle.
REQ-019 Speculative GHR shifts in pred at each edge where IF hits a conditional-branch entry.
REQ-020 ID allocate: id_is_jump or id_is_btype with ID-stage hit=0 writes {1, tag, id_branchtarget, id_is_jump} to the BTB; the PHT is not written.
REQ-021 id_jump_in_bht = id_is_jump AND ID-stage hit AND ID-stage pred.
REQ-022 EXE update when exe_is_btype and EXE metadata valid: counter at the carried pht_idx +1 if taken, -1 if not, saturating at 0 and 2^CTR_W-1.
REQ-023 Mispredict when pred != exe_taken: exe_correction = 2'b10 (predicted taken, not taken; redirect to exe_CNI = exe_PC+1, wrapping mod 2^PC_W) or 2'b11 (predicted not taken, taken; redirect to exe_PBT = exe_target); otherwise 2'b00.
REQ-024 flush = (exe_correction != 0); combinational, same cycle.
REQ-025 On flush: GHR <= {snapshot, exe_taken} (shifted); IF/ID metadata cleared to invalid; ID allocation that cycle suppressed.
REQ-026 Same-cycle read and write to one BTB or PHT index: the read returns the old value.
REQ-027 ID allocation and EXE update in one cycle both commit (separate tables).
REQ-028 Invalid EXE metadata (bubble/flushed): no PHT update, exe_correction = 0.

Reset
REQ-029 While nrst=0 at an edge: all valid bits 0, counters 2^(CTR_W-1)-1 (weakly not-taken), GHR 0, metadata invalid.
REQ-030 After reset: if_prediction 0, if_PBT 0, id_jump_in_bht 0, exe_correction 0, flush 0, exe_PBT 0, exe_CNI = exe_PC+1.
REQ-031 Reset asserted mid-operation overrides any simultaneous allocate, update or GHR recovery.

Structure
REQ-032 Package bpred_pkg holds CORR_NONE/CORR_CNI/CORR_PBT encodings, the metadata struct and the counter-init function.
REQ-033 Sub-module pht_array (counter storage, saturating update, read-old) is instantiated once.

Verification
REQ-034 Reset, then if_PC=0x010 -> if_prediction=0, if_PBT=0, flush=0.
REQ-035 JAL at PC 0x010 to 0x040, ID miss -> allocated; re-fetch 0x010 -> if_prediction=1, if_PBT=0x040; in ID id_jump_in_bht=1.
REQ-036 BEQ at 0x020 taken 3x (target 0x008), defaults -> first resolve corr=2'b11, exe_PBT=0x008, flush=1; after counter reaches 3, fetch predicts taken.
REQ-037 Trained taken branch at 0x020 resolves not-taken -> corr=2'b10, exe_CNI=0x021, GHR restored to snapshot<<1; IF/ID metadata invalid next cycle.
REQ-038 Branch at 0x3FF mispredicted not-taken -> exe_CNI=0x000 (wrap); counter saturates at 0 after further not-taken.
REQ-039 nrst=0 for one cycle while a mispredict is in EXE -> no PHT write, all outputs at reset values next cycle.
